// File: rtl/nav_controller_if.sv
// nav_controller_if: command/range inputs and motor-drive outputs of nav_controller
// Signals: enable_i, turn_mode_i, dist_i, dist_valid_i, duty1_i, duty2_i toward the controller;
//   dir1_o, dir2_o, duty1_o, duty2_o, state_o, close_o from the controller.
// Modports: master drives commands and samples (bench/host), slave is the controller.
interface nav_controller_if;
  logic enable_i;
  logic turn_mode_i;
  logic [15:0] dist_i;
  logic dist_valid_i;
  logic [7:0] duty1_i;
  logic [7:0] duty2_i;
  logic dir1_o;
  logic dir2_o;
  logic [7:0] duty1_o;
  logic [7:0] duty2_o;
  logic [2:0] state_o;
  logic close_o;
  modport master (
    output enable_i, turn_mode_i, dist_i, dist_valid_i, duty1_i, duty2_i,
    input dir1_o, dir2_o, duty1_o, duty2_o, state_o, close_o
  );
  modport slave (
    input enable_i, turn_mode_i, dist_i, dist_valid_i, duty1_i, duty2_i,
    output dir1_o, dir2_o, duty1_o, duty2_o, state_o, close_o
  );
endinterface

// File: rtl/nav_controller.sv
// nav_controller: obstacle-avoiding drive FSM fed by a median-filtered ultrasonic range
// Ports: clk_i system clock; rst_ni async active-low reset;
//   bus (slave): enable_i, turn_mode_i, dist_i/dist_valid_i, duty1_i/duty2_i in;
//   dir1_o/dir2_o, duty1_o/duty2_o, state_o, close_o out.
module nav_controller #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CLOSE_CM = 20,
  parameter int unsigned FAR_CM = 25,
  parameter int unsigned BRAKE_MS = 100,
  parameter int unsigned BACK_MS = 500,
  parameter int unsigned TURN_MS = 800
) (
  input logic clk_i,
  input logic rst_ni,
  nav_controller_if.slave bus
);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [15:0] CLOSE_T = 16'(CLOSE_CM);
  localparam logic [15:0] FAR_T = 16'(FAR_CM);
  localparam logic [15:0] BRAKE_T = 16'(BRAKE_MS);
  localparam logic [15:0] BACK_T = 16'(BACK_MS);
  localparam logic [15:0] TURN_T = 16'(TURN_MS);
  typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, BRAKE = 3'd2, BACK = 3'd3, TURN = 3'd4} state_e;
  state_e state_q, state_d;
  logic [2:0][15:0] hist_q, hist_d;
  logic [1:0] cnt_q, cnt_d;
  logic close_q, close_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0] dir_q, dir;
  logic [15:0] duty;
  logic [15:0] med;
  logic tick;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      hist_q <= '0;
      cnt_q <= '0;
      close_q <= 1'b0;
      tick_q <= '0;
      timer_q <= '0;
      dir_q <= 2'b11;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      cnt_q <= cnt_d;
      close_q <= close_d;
      tick_q <= tick_d;
      timer_q <= timer_d;
      dir_q <= dir;
    end
  assign med = (hist_q[0] >= hist_q[1])
    ? ((hist_q[1] >= hist_q[2]) ? hist_q[1] : (hist_q[0] >= hist_q[2]) ? hist_q[2] : hist_q[0])
    : ((hist_q[0] >= hist_q[2]) ? hist_q[0] : (hist_q[1] >= hist_q[2]) ? hist_q[2] : hist_q[1]);
  assign tick = tick_q == TICK_MAX;
  // Hysteresis is re-evaluated every cycle on the held median; that is idempotent between strobes.
  always_comb begin
    hist_d = bus.dist_valid_i ? {hist_q[1:0], bus.dist_i} : hist_q;
    cnt_d = (bus.dist_valid_i && cnt_q != 2'd3) ? cnt_q + 2'd1 : cnt_q;
    close_d = (cnt_q != 2'd3) ? 1'b0 : (med < CLOSE_T) ? 1'b1 : (med >= FAR_T) ? 1'b0 : close_q;
    tick_d = tick ? '0 : tick_q + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    dir = 2'b11;
    duty = '0;
    case (state_q)
      IDLE: state_d = FWD;
      FWD: begin
        duty = {bus.duty1_i, bus.duty2_i};
        if (close_q) state_d = BRAKE;
      end
      BRAKE: begin
        dir = dir_q;
        if (timer_q == BRAKE_T) state_d = bus.turn_mode_i ? TURN : BACK;
      end
      BACK: begin
        dir = 2'b00;
        duty = {bus.duty1_i, bus.duty2_i};
        if (!close_q && timer_q >= BACK_T) state_d = FWD;
      end
      TURN: begin
        dir = 2'b01;
        duty = {bus.duty1_i, bus.duty2_i};
        if (timer_q == TURN_T) state_d = FWD;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable_i) state_d = IDLE;
    // Entry reload wins over a coincident tick; BACK restarts its wait while the obstacle persists.
    timer_d = (state_d != state_q || (state_q == BACK && close_q)) ? '0
      : (tick && timer_q != '1) ? timer_q + 16'd1 : timer_q;
  end
  assign bus.state_o = state_q;
  assign {bus.dir1_o, bus.dir2_o} = dir;
  assign {bus.duty1_o, bus.duty2_o} = duty;
  assign bus.close_o = close_q;
endmodule
